timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer peripheral on the CPU bridge. It raises an interrupt request that drives one bit of the processor's 6-bit `HWInt` vector into the coprocessor-0 exception unit. Software programs it through three word registers: CTRL, PRESET and COUNT. It supports one-shot and auto-reload modes.

## Interface
Parameters:
- none (register widths fixed at 32 bits; word offsets fixed)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `Addr`  in  2  word offset within the device (byte address bits [3:2])
- `WE`  in  1  write enable from the bridge, valid for one cycle
- `Din`  in  32  write data
- `Dout`  out  32  read data, combinational from `Addr`
- `IRQ`  out  1  interrupt request to `HWInt`, registered

## Operation
- Registers:
  - CTRL: only bits [3:0] are stored; upper bits read 0.
    - bit 0: Enable
    - bits 2:1: Mode (00 one-shot, 01 auto-reload, 1x treated as one-shot)
    - bit 3: IM (interrupt mask; 1 = allow)
  - PRESET: 32-bit reload value.
  - COUNT: 32-bit, read-only.
  - Internal: `irq_flag` and a 2-bit FSM state.
- Writes with `WE`=1:
  - Addr 0: CTRL <= Din[3:0]. Also clears `irq_flag`.
  - Addr 1: PRESET <= Din.
  - Addr 2 and 3: ignored.
- Reads: Addr 0 returns {28'b0, CTRL}; Addr 1 returns PRESET; Addr 2 returns COUNT; Addr 3 returns 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable=1, go to LOAD. COUNT holds its value.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If Enable=0, go to IDLE; COUNT freezes.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else (COUNT is 0 or 1): COUNT <= 0, `irq_flag` <= 1, go to INT.
  - INT, one-shot mode: Enable <= 0; go to IDLE. `irq_flag` stays 1 until software writes CTRL.
  - INT, auto-reload mode: `irq_flag` <= 0; go to LOAD.
- `IRQ` = `irq_flag` & IM. Masking never clears `irq_flag`, so setting IM=1 later exposes a pending request.
- COUNT never wraps below 0. PRESET=0 behaves like PRESET=1.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, `irq_flag`=0, `IRQ`=0; `Dout`=0 at every Addr.
- Edge numbering: edge 0 is the CTRL write that sets Enable=1 with PRESET=N≥1.
  - Edge 1: state enters LOAD.
  - Edge 2: COUNT=N.
  - Edge N+1: COUNT=1.
  - Edge N+2: COUNT=0, state=INT, `IRQ`=1 (if IM=1).
- Auto-reload: `IRQ` pulses high for exactly 1 cycle every N+2 cycles.
- One-shot: `IRQ` stays high from edge N+2 until the edge of a CTRL write.
- Simultaneous events:
  - CTRL write and FSM clearing Enable in the same cycle: the software value wins, and `irq_flag` clears.
  - CTRL write and `irq_flag` being set in the same cycle: the clear wins.
- PRESET write during CNT: no effect on the current count; used at the next LOAD.
- Disable during CNT: IDLE on the next edge with COUNT frozen. Re-enabling goes through LOAD, so COUNT reloads from PRESET.
- Reset asserted mid-count or in INT: all state returns to reset values on that edge, and `IRQ` drops immediately after it.

## Structure
- Shared `Const.v` macros:
  - FSM state encodings (IDLE=0, LOAD=1, CNT=2, INT=3)
  - CTRL field positions (Enable, Mode, IM)
  - word offsets (CTRL=0, PRESET=1, COUNT=2)
  - the `HWInt` bit index this timer drives
- Single module `timer_dev` with no sub-module. The bridge instantiates it twice (timer0, timer1), on separate `HWInt` bits.

## Test plan
- Reset, then read Addr 0/1/2/3 -> all 0; `IRQ`=0.
- PRESET=5, CTRL=4'b1001 (one-shot, IM) -> COUNT reads 5,4,3,2,1,0 on edges 2..7. `IRQ` rises after edge 7 and stays high. CTRL reads 4'b1000. Writing CTRL=0 drops `IRQ` the next cycle.
- PRESET=3, CTRL=4'b1011 (auto-reload) -> `IRQ` is a 1-cycle pulse every 5 cycles for at least 4 periods; CTRL unchanged.
- PRESET=4, CTRL=4'b0001 (IM=0) -> reaches INT with `IRQ`=0. A later write to CTRL setting IM=1 also clears the flag, so `IRQ` stays 0 (confirms write-clears-flag).
- Mid-count: at COUNT=2, write PRESET=10 -> the current expiry is unaffected. Write CTRL Enable=0 at COUNT=6 -> COUNT holds 6. Re-enable -> COUNT reloads to 10.
- Assert `reset` while `IRQ`=1 in one-shot mode -> next cycle `IRQ`=0, all registers 0, state IDLE.

Source files
------------

// File: rtl/timer_dev_pkg.sv
// -----------------------------------------------------------------------------
// timer_dev_pkg
//   Shared definitions for the memory-mapped countdown timer:
//     - FSM state encoding (IDLE=0, LOAD=1, CNT=2, INT=3)
//     - CTRL field positions (Enable, Mode, IM) and the auto-reload mode code
//     - word offsets of the software-visible registers
//     - HWInt bit indices driven by the two bridge instances
//     - read_word(): the register read multiplexer
// -----------------------------------------------------------------------------
package timer_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // CTRL field positions
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    // Only 2'b01 reloads; 2'b00 and 2'b1x both behave as one-shot.
    localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

    // Word offsets (byte address bits [3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // HWInt bits used by the two timer instances on the bridge
    localparam int TIMER0_HWINT_BIT = 2;
    localparam int TIMER1_HWINT_BIT = 3;

    // Register read mux; unmapped offset 3 reads as zero.
    function automatic logic [31:0] read_word(
        input logic [1:0]  addr,
        input logic [3:0]  ctrl,
        input logic [31:0] preset,
        input logic [31:0] count
    );
        logic [31:0] word;
        word = 32'd0;
        case (addr)
            OFF_CTRL:   word = {28'd0, ctrl};
            OFF_PRESET: word = preset;
            OFF_COUNT:  word = count;
            default:    word = 32'd0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
//   Countdown timer peripheral with one-shot and auto-reload modes. Raises a
//   registered interrupt request (IRQ = irq_flag & IM) for one HWInt bit.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset, clears all state
//   Addr   in   2   word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 unused)
//   WE     in   1   single-cycle write strobe
//   Din    in  32   write data
//   Dout   out 32   read data, combinational from Addr
//   IRQ    out  1   registered interrupt request
// -----------------------------------------------------------------------------
module timer_dev
    import timer_dev_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q,      irq_d;
    state_e      state_q,    state_d;

    logic        enable;
    logic        auto_reload;

    assign enable      = ctrl_q[CTRL_EN_BIT];
    assign auto_reload = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_AUTO_RELOAD);

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Handles COUNT==0 too, so PRESET=0 expires like PRESET=1
                    // and the counter can never wrap.
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Software writes are applied last so they override any FSM update
        // in the same cycle (CTRL value wins, and the flag clear wins).
        if (WE) begin
            case (Addr)
                OFF_CTRL: begin
                    ctrl_d     = Din[3:0];
                    irq_flag_d = 1'b0;
                end
                OFF_PRESET: begin
                    preset_d = Din;
                end
                default: begin
                end
            endcase
        end

        // IRQ is registered from next-state values so it rises on the same
        // edge that sets the flag and falls on the edge of the CTRL write.
        irq_d = irq_flag_d & ctrl_d[CTRL_IM_BIT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
        end
    end

    assign Dout = read_word(Addr, ctrl_q, preset_q, count_q);
    assign IRQ  = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  Addr = 2'd0;
    logic        WE = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        WE    = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------ reference model
    // Time-based view of a timer run: m_age counts edges since the run began
    // (0 = not running, 1 = reload edge pending). A run expires at age
    // max(N,1)+2 and the count at age a is max(N-(a-2),0).
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;
    bit          m_irq;
    int          m_age;
    int          m_n;

    task automatic model_step(input bit rst, input bit we, input logic [1:0] a,
                              input logic [31:0] d);
        logic [3:0]  c;
        logic [31:0] p;
        logic [31:0] cnt;
        bit          f;
        int          age;
        int          n;
        int          expiry;
        c = m_ctrl; p = m_preset; cnt = m_count; f = m_flag; age = m_age; n = m_n;
        if (rst) begin
            c = 4'd0; p = 32'd0; cnt = 32'd0; f = 1'b0; age = 0; n = 0;
        end else begin
            expiry = ((m_n < 1) ? 1 : m_n) + 2;
            if (m_age == 0) begin
                if (m_ctrl[0]) age = 1;
            end else if (m_age == 1) begin
                n   = int'(m_preset);
                cnt = m_preset;
                age = 2;
            end else if (m_age < expiry) begin
                if (!m_ctrl[0]) begin
                    age = 0;
                end else begin
                    age = m_age + 1;
                    cnt = ((m_n - (age - 2)) > 0) ? 32'(m_n - (age - 2)) : 32'd0;
                    if (age == expiry) f = 1'b1;
                end
            end else begin
                if (m_ctrl[2:1] == 2'b01) begin
                    f   = 1'b0;
                    age = 1;
                end else begin
                    c[0] = 1'b0;
                    age  = 0;
                end
            end
            if (we && a == 2'd0) begin
                c = d[3:0];
                f = 1'b0;
            end
            if (we && a == 2'd1) p = d;
        end
        m_ctrl = c; m_preset = p; m_count = cnt; m_flag = f; m_age = age; m_n = n;
        m_irq  = f & c[3];
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_checks++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, v);
            end
        end
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
        $display("test_reset done");
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);          // edge 0
        tick();                   // edge 1
        for (int k = 2; k <= 7; k++) begin
            tick();
            rd(2'd2, v);
            n_checks++;
            if (v !== 32'(7 - k)) begin
                n_fail++;
                $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", k, v, 7 - k);
            end
            n_checks++;
            if (IRQ !== (k == 7)) begin
                n_fail++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", k, IRQ, (k == 7));
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if (IRQ !== 1'b1) begin
                n_fail++;
                $display("FAIL oneshot_irq_hold step=%0d got=%b exp=1", k, IRQ);
            end
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'h8) begin
            n_fail++;
            $display("FAIL oneshot_ctrl got=%h exp=8", v);
        end
        wr(2'd0, 32'h0);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_clear got=%b exp=0", IRQ);
        end
        $display("test_oneshot done");
    endtask

    task automatic test_autoreload();
        logic [31:0] v;
        bit          exp;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);          // edge 0
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp = (k >= 5) && ((k - 5) % 5 == 0);
            n_checks++;
            if (IRQ !== exp) begin
                n_fail++;
                $display("FAIL auto_irq edge=%0d got=%b exp=%b", k, IRQ, exp);
            end
        end
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'hB) begin
            n_fail++;
            $display("FAIL auto_ctrl got=%h exp=b", v);
        end
        $display("test_autoreload done");
    endtask

    task automatic test_masked();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);          // edge 0, IM=0
        repeat (6) tick();        // edge 6: expiry
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd0 || IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_expiry count=%0d irq=%b exp count=0 irq=0", v, IRQ);
        end
        tick();                   // edge 7: back to idle, Enable dropped
        rd(2'd0, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL masked_ctrl got=%h exp=0", v);
        end
        wr(2'd0, 32'h8);          // IM=1 write clears pending flag
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_unmask got=%b exp=0", IRQ);
        end
        tick();
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL masked_unmask_hold got=%b exp=0", IRQ);
        end
        $display("test_masked done");
    endtask

    task automatic test_midcount();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);          // edge 0
        repeat (6) tick();        // edge 6: COUNT=2
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd2) begin
            n_fail++;
            $display("FAIL mid_count2 got=%0d exp=2", v);
        end
        wr(2'd1, 32'd10);         // edge 7
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd1) begin
            n_fail++;
            $display("FAIL mid_after_preset got=%0d exp=1", v);
        end
        tick();                   // edge 8: expiry unaffected
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd0 || IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_expiry count=%0d irq=%b exp count=0 irq=1", v, IRQ);
        end
        wr(2'd0, 32'h0);
        wr(2'd0, 32'h9);          // new run with PRESET=10, edge 0
        repeat (5) tick();        // edge 5: COUNT=7
        wr(2'd0, 32'h8);          // edge 6: COUNT=6, Enable now 0
        repeat (4) tick();
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd6) begin
            n_fail++;
            $display("FAIL mid_freeze got=%0d exp=6", v);
        end
        wr(2'd0, 32'h9);          // re-enable, edge 0
        tick();
        tick();                   // edge 2
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd10) begin
            n_fail++;
            $display("FAIL mid_reload got=%0d exp=10", v);
        end
        $display("test_midcount done");
    endtask

    task automatic test_reset_in_int();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);          // edge 0
        repeat (4) tick();        // edge 4: expiry
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL rstint_pre got=%b exp=1", IRQ);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL rstint_irq got=%b exp=0", IRQ);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            n_checks++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL rstint_read addr=%0d got=%h exp=0", a, v);
            end
        end
        repeat (3) tick();
        rd(2'd2, v);
        n_checks++;
        if (v !== 32'd0 || IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL rstint_idle count=%0d irq=%b exp 0/0", v, IRQ);
        end
        $display("test_reset_in_int done");
    endtask

    task automatic test_random();
        bit          rst;
        bit          we;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        int          bad = 0;
        do_reset();
        model_step(1'b1, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            we  = ($urandom_range(0, 3) == 0);
            a   = 2'($urandom_range(0, 3));
            if (a == 2'd0)
                d = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7)) << 1 |
                    32'($urandom_range(0, 3) != 0);
            else if (a == 2'd1)
                d = 32'($urandom_range(0, 6));
            else
                d = $urandom;
            reset = rst;
            WE    = we;
            Addr  = a;
            Din   = d;
            #1;
            exp_rd = model_read(a);
            n_checks++;
            if (Dout !== exp_rd) begin
                n_fail++;
                bad++;
                $display("FAIL rand_dout cyc=%0d addr=%0d got=%h exp=%h", i, a, Dout, exp_rd);
            end
            @(posedge clk);
            model_step(rst, we, a, d);
            #1;
            n_checks++;
            if (IRQ !== m_irq) begin
                n_fail++;
                bad++;
                $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, IRQ, m_irq);
            end
        end
        reset = 1'b0;
        WE    = 1'b0;
        $display("test_random done, %0d bad cycles", bad);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_midcount();
        test_reset_in_int();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
